mips_regfile: RTL and testbench

Architectural register file for the 32-bit MIPS datapath: 32 × 32-bit registers, one synchronous write port and two asynchronous read ports. The block is the steering counterpart of the datapath's 2:1 and wider selection muxes. A 5-to-32 one-hot write decoder fans one write word out to exactly one register, and the read side selects two registers back into the ALU operand path. It sits between instruction decode (register indices) and the ALU/write-back mux.

---
 rtl/mips_regfile_pkg.sv | 20 ++
 rtl/mips_regfile_decoder5_to_32.sv | 18 +
 rtl/mips_regfile.sv | 78 +++++++
 tb/tb_mips_regfile.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mips_regfile_pkg.sv
// Shared datapath constants and types for the MIPS core: register index width,
// word width and the architecturally named register indices used by decode and jal/jr.
package mips_regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]     data_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_AT   = 5'd1;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/mips_regfile_decoder5_to_32.sv
// 5-to-32 one-hot decoder with enable; output is all zero when disabled.
// Purely combinational, no backpressure. Bit 0 is left to the caller to mask.
module decoder5_to_32
  import mips_regfile_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] idx_i,
  input  logic                  en_i,
  output logic [31:0]           onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/mips_regfile.sv
// MIPS register file: 32 x DATA_W, one synchronous write port, two combinational read ports.
// Write visible next cycle (same cycle when BYPASS=1); reads have zero latency; no backpressure.
module mips_regfile
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [4:0]        writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [4:0]        readReg1,
  input  logic [4:0]        readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [31:0]         dec_vec;
  logic [NUM_REGS-1:0] wr_en;
  logic                byp_hit1;
  logic                byp_hit2;

  decoder5_to_32 u_wr_dec (
    .idx_i    (writeReg),
    .en_i     (regWrite),
    .onehot_o (dec_vec)
  );

  // r0 is masked here rather than in the decoder so its flop never leaves zero.
  assign wr_en = dec_vec & ~32'd1;

  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_en[k]) begin
        regs_d[k] = writeData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // A write under reset is discarded, so it must not be forwarded either.
  assign byp_hit1 = regWrite && !reset && (writeReg == readReg1);
  assign byp_hit2 = regWrite && !reset && (writeReg == readReg2);

  always_comb begin
    readData1 = '0;
    if (!is_zero_reg(readReg1)) begin
      readData1 = regs_q[readReg1];
      if ((BYPASS != 0) && byp_hit1) begin
        readData1 = writeData;
      end
    end
  end

  always_comb begin
    readData2 = '0;
    if (!is_zero_reg(readReg2)) begin
      readData2 = regs_q[readReg2];
      if ((BYPASS != 0) && byp_hit2) begin
        readData2 = writeData;
      end
    end
  end

endmodule

// File: tb/tb_mips_regfile.sv
// Directed scoreboard bench: drives one vector per cycle into a BYPASS=0 and a BYPASS=1
// instance in parallel; a negedge monitor pops the expected reads and compares.
module tb_mips_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] rd1_b0, rd2_b0, rd1_b1, rd2_b1;

  always #5 clk = ~clk;

  mips_regfile #(.DATA_W(32), .NUM_REGS(32), .BYPASS(0)) u_dut_b0 (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1_b0), .readData2(rd2_b0)
  );

  mips_regfile #(.DATA_W(32), .NUM_REGS(32), .BYPASS(1)) u_dut_b1 (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1_b1), .readData2(rd2_b1)
  );

  typedef struct {
    string       name;
    logic [31:0] e1_b0;
    logic [31:0] e2_b0;
    logic [31:0] e1_b1;
    logic [31:0] e2_b1;
  } exp_t;

  localparam logic [31:0] STEP = 32'h01010101;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic cmp(input string nm, input string port, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %h, expected %h", nm, port, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_underflow: got 0 entries, expected >= 1");
      end else begin
        e = exp_q.pop_front();
        cmp(e.name, "rd1_bypass0", rd1_b0, e.e1_b0);
        cmp(e.name, "rd2_bypass0", rd2_b0, e.e2_b0);
        cmp(e.name, "rd1_bypass1", rd1_b1, e.e1_b1);
        cmp(e.name, "rd2_bypass1", rd2_b1, e.e2_b1);
      end
    end
  end

  task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic chk, input string nm,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] b1, input logic [31:0] b2);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    regWrite  = we;
    writeReg  = wr;
    writeData = wd;
    readReg1  = r1;
    readReg2  = r2;
    chk_vld   = chk;
    if (chk) begin
      e.name  = nm;
      e.e1_b0 = a1;
      e.e2_b0 = a2;
      e.e1_b1 = b1;
      e.e2_b1 = b2;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    logic [31:0] v1, v2;
    reset = 1'b1; regWrite = 1'b0; writeReg = 5'd0; writeData = '0;
    readReg1 = 5'd0; readReg2 = 5'd0;

    // Reset held two cycles, then every index reads zero on both ports.
    drive(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, "rst", 0, 0, 0, 0);
    drive(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, "rst", 0, 0, 0, 0);
    for (int i = 0; i < 32; i++)
      drive(0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1, "reset_sweep", 0, 0, 0, 0);

    // Basic write / read.
    drive(0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1, "wr_r5", 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    drive(0, 0, 5'd5, 32'h0, 5'd5, 5'd5, 1, "rd_r5", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    drive(0, 0, 5'd0, 32'h0, 5'd4, 5'd6, 1, "rd_r4_r6", 0, 0, 0, 0);

    // r0 write is dropped and never forwarded.
    drive(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1, "wr_r0", 0, 0, 0, 0);
    drive(0, 0, 5'd0, 32'h0, 5'd0, 5'd5, 1, "rd_r0", 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);

    // Populate r8 and r7, then bypass a new r7 while reading r8.
    drive(0, 1, 5'd8, 32'h11112222, 5'd8, 5'd0, 1, "wr_r8", 0, 0, 32'h11112222, 0);
    drive(0, 1, 5'd7, 32'h33334444, 5'd7, 5'd8, 1, "wr_r7", 0, 32'h11112222, 32'h33334444, 32'h11112222);
    drive(0, 1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd8, 1, "bypass_r7", 32'h33334444, 32'h11112222, 32'hA5A5A5A5, 32'h11112222);
    drive(0, 0, 5'd7, 32'h0, 5'd7, 5'd8, 1, "after_bypass", 32'hA5A5A5A5, 32'h11112222, 32'hA5A5A5A5, 32'h11112222);

    // Same register written back-to-back: last write wins.
    drive(0, 1, 5'd9, 32'h00000001, 5'd9, 5'd9, 1, "r9_first", 0, 0, 32'h1, 32'h1);
    drive(0, 1, 5'd9, 32'h00000002, 5'd9, 5'd9, 1, "r9_second", 32'h1, 32'h1, 32'h2, 32'h2);
    drive(0, 0, 5'd9, 32'h0, 5'd9, 5'd7, 1, "r9_final", 32'h2, 32'hA5A5A5A5, 32'h2, 32'hA5A5A5A5);

    // Reset beats a simultaneous write and suppresses bypass; clears a populated file.
    drive(1, 1, 5'd31, 32'h12345678, 5'd31, 5'd7, 1, "rst_vs_wr", 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5);
    drive(0, 0, 5'd0, 32'h0, 5'd31, 5'd7, 1, "post_rst_a", 0, 0, 0, 0);
    drive(0, 0, 5'd0, 32'h0, 5'd8, 5'd9, 1, "post_rst_b", 0, 0, 0, 0);
    drive(0, 0, 5'd0, 32'h0, 5'd5, 5'd31, 1, "post_rst_c", 0, 0, 0, 0);

    // Full sweep with regWrite=0 gaps carrying random data and index.
    for (int k = 1; k < 32; k++) begin
      v1 = 32'(k) * STEP;
      v2 = 32'(k - 1) * STEP;
      drive(0, 1, 5'(k), v1, 5'(k), 5'(k - 1), 1, "sweep_wr", 0, v2, v1, v2);
      drive(0, 0, 5'($urandom_range(0, 31)), $urandom, 5'(k), 5'd0, 1, "sweep_gap", v1, 0, v1, 0);
    end
    for (int i = 0; i < 32; i++) begin
      v1 = 32'(i) * STEP;
      v2 = 32'(31 - i) * STEP;
      drive(0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1, "sweep_rd", v1, v2, v1, v2);
    end

    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    regWrite = 1'b0;
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
